vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator that replaces the separate fixed 640x480 horizontal and vertical counters with a single block. It derives a pixel tick from the system clock with an integer divider and runs nested horizontal and vertical counters from that tick. It also produces aligned hsync, vsync, active-video and line/frame strobes. The block sits between the system clock domain and the Pong renderer and VGA pins.

## Interface
- `CW`, 10: width of the `hcount` and `vcount` outputs; H_TOTAL and V_TOTAL must both be ≤ 2^CW.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal segment lengths in pixels. H_TOTAL = sum = 800.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical segment lengths in lines. V_TOTAL = sum = 525.
- `H_POL`, 0; `V_POL`, 0: sync active level (0 = active-low).
- `CLK_DIV`, 2: system clocks per pixel, ≥1.
- `FW`, 16: frame counter width (only with the macro).

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: run; low freezes all state.
- `pix_tick` out 1: one-clk pulse per pixel period.
- `hcount` out CW: pixel index in line, 0..H_TOTAL-1.
- `vcount` out CW: line index in frame, 0..V_TOTAL-1.
- `hsync` out 1: horizontal sync, at H_POL level while asserted.
- `vsync` out 1: vertical sync, at V_POL level while asserted.
- `active` out 1: high when hcount < H_ACTIVE and vcount < V_ACTIVE.
- `line_start` out 1: one-clk pulse after hcount wraps to 0.
- `frame_start` out 1: one-clk pulse after hcount and vcount both wrap to 0.
- `frame_cnt` out FW: frames completed (only with the macro).

## Operation
- The prescaler `div` counts 0..CLK_DIV-1 on every clk while `enable` is high. When `div` reaches CLK_DIV-1 it wraps to 0 and `pix_tick` is 1. With CLK_DIV = 1, `pix_tick` equals `enable`.
- On each `pix_tick`, hcount advances. If hcount < H_TOTAL-1 it increments. Otherwise it returns to 0 and vcount advances the same way (wraps from V_TOTAL-1 to 0).
- hsync is asserted when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC. Defaults: 656..751.
- vsync is asserted when V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC. Defaults: 490..491.
- hsync, vsync and active are registered and computed from the next-state counts. They therefore change in the same clk edge as hcount/vcount, with zero skew to the counts.
- `line_start` is 1 for exactly one clk, in the cycle where the registered hcount first equals 0 after a wrap. `frame_start` is the same, for the wrap to (0,0).
- When `enable` is low, div, the counts, the sync levels and active all hold. pix_tick, line_start and frame_start are 0.
- Reset mid-frame takes effect immediately, regardless of clk, and restarts the frame at (0,0).

## Timing
- Reset values:
  - `div` = 0, `hcount` = 0, `vcount` = 0.
  - `hsync` = ~H_POL, `vsync` = ~V_POL (inactive).
  - `active` = 1, since (0,0) is an active pixel.
  - `pix_tick`, `line_start`, `frame_start` = 0.
  - `frame_cnt` = 0.
- First count update: the first pix_tick occurs CLK_DIV clks after rst_n deasserts with enable high. hcount = 1 on the following edge.
- Line period is H_TOTAL·CLK_DIV clks. Frame period is H_TOTAL·V_TOTAL·CLK_DIV clks.
- No reset strobe: line_start and frame_start are not generated at reset release, only on a wrap.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - The `frame_cnt` port and register exist.
  - `frame_cnt` increments modulo 2^FW in the same edge that `frame_start` rises.
- Macro undefined: no `frame_cnt` port and no related logic. All other behaviour is identical.

## Test plan
- Reset: hold rst_n low with clk running. Required: hcount = vcount = 0, hsync = vsync = 1, active = 1, strobes = 0. Assert rst_n mid-frame at (300,200): outputs return to the reset values with no clk edge needed.
- Line, defaults with CLK_DIV=1: hsync is low exactly for hcount 656..751; active drops at hcount 640; hcount 799 → 0 with vcount +1 and line_start pulsing 1 clk.
- Frame wrap: (799,524) → (0,0). Required: frame_start and line_start each 1 clk; vsync low only on lines 490..491; active low for vcount ≥ 480. With the macro, frame_cnt 0 → 1.
- Divider, CLK_DIV=4: pix_tick every 4th clk; hcount 0 → 1 after 4 clks; line period 3200 clks.
- Enable gating: drop enable at hcount = 655 for 10 clks. Required: all state frozen, no pix_tick; hsync asserts at 656 exactly one tick after enable returns.
- Polarity, H_POL=1, V_POL=1: sync pulses high at the same positions; reset value of hsync/vsync = 0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundle between the VGA timing generator and its consumers (renderer,
//   VGA pin drivers). The generator takes the master modport; consumers
//   take the slave modport.
//
//   enable      : run request from the consumer side; low freezes the raster
//   pix_tick    : one-clk pulse per pixel period
//   hcount      : pixel index within the line
//   vcount      : line index within the frame
//   hsync/vsync : sync outputs, already at the configured polarity
//   active      : visible-area flag, aligned with hcount/vcount
//   line_start  : one-clk pulse when hcount has just wrapped to 0
//   frame_start : one-clk pulse when (hcount,vcount) has just wrapped to (0,0)
//   frame_cnt   : completed-frame counter (only with VGA_TIMING_FRAME_CNT_EN)
interface vga_timing_gen_if #(
  parameter int CW = 10
`ifdef VGA_TIMING_FRAME_CNT_EN
  , parameter int FW = 16
`endif
);
  logic          enable;
  logic          pix_tick;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FW-1:0] frame_cnt;

  modport master (
    input  enable,
    output pix_tick, hcount, vcount, hsync, vsync, active,
           line_start, frame_start, frame_cnt
  );
  modport slave (
    output enable,
    input  pix_tick, hcount, vcount, hsync, vsync, active,
           line_start, frame_start, frame_cnt
  );
`else
  modport master (
    input  enable,
    output pix_tick, hcount, vcount, hsync, vsync, active,
           line_start, frame_start
  );
  modport slave (
    output enable,
    input  pix_tick, hcount, vcount, hsync, vsync, active,
           line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. An integer prescaler derives a
//   pixel tick from clk; nested horizontal/vertical counters advance on that
//   tick. Sync, active and line/frame strobes are registered from the
//   next-state counts so they change on the same edge as the counts.
//
//   Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds the FW parameter and
//   the frame_cnt output (frames completed, modulo 2^FW).
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset; restarts the raster at (0,0)
//     bus   : vga_timing_gen_if.master (enable in; pix_tick, hcount, vcount,
//             hsync, vsync, active, line_start, frame_start[, frame_cnt] out)
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 2
`ifdef VGA_TIMING_FRAME_CNT_EN
  , parameter int FW     = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_timing_gen_if.master    bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;
  // A divide-by-1 prescaler still gets a 1-bit register that simply stays 0.
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);

  function automatic logic hsync_level(input logic [CW-1:0] h);
    return ((int'(h) >= HS_BEG) && (int'(h) < HS_END)) ? H_POL : ~H_POL;
  endfunction

  function automatic logic vsync_level(input logic [CW-1:0] v);
    return ((int'(v) >= VS_BEG) && (int'(v) < VS_END)) ? V_POL : ~V_POL;
  endfunction

  function automatic logic in_active(input logic [CW-1:0] h,
                                     input logic [CW-1:0] v);
    return (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  endfunction

  logic [DIV_W-1:0] div;
  logic [CW-1:0]    hcount_r;
  logic [CW-1:0]    vcount_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             active_r;
  logic             line_start_r;
  logic             frame_start_r;

  logic             div_last;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [CW-1:0]    h_nxt;
  logic [CW-1:0]    v_nxt;

  // Next-state counts; sync/active are decoded from these so the registered
  // flags line up with the registered counts without a one-pixel lag.
  always_comb begin
    div_last = (div == DIV_LAST);
    tick     = bus.enable & div_last;
    h_wrap   = (hcount_r == H_LAST);
    v_wrap   = (vcount_r == V_LAST);
    h_nxt    = h_wrap ? '0 : hcount_r + CW'(1);
    v_nxt    = vcount_r;
    if (h_wrap) begin
      v_nxt  = v_wrap ? '0 : vcount_r + CW'(1);
    end
  end

  // Strobes default low every clk so they last exactly one clk after a
  // wrapping tick, and stay low while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div           <= '0;
      hcount_r      <= '0;
      vcount_r      <= '0;
      hsync_r       <= ~H_POL;
      vsync_r       <= ~V_POL;
      active_r      <= 1'b1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      if (bus.enable) begin
        div <= div_last ? '0 : div + DIV_W'(1);
      end
      if (tick) begin
        hcount_r      <= h_nxt;
        vcount_r      <= v_nxt;
        hsync_r       <= hsync_level(h_nxt);
        vsync_r       <= vsync_level(v_nxt);
        active_r      <= in_active(h_nxt, v_nxt);
        line_start_r  <= h_wrap;
        frame_start_r <= h_wrap & v_wrap;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FW-1:0] frame_cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= '0;
    end else if (tick && h_wrap && v_wrap) begin
      frame_cnt_r <= frame_cnt_r + FW'(1);
    end
  end

  assign bus.frame_cnt = frame_cnt_r;
`endif

  // pix_tick is combinational so the count update lands on the edge that
  // closes the tick cycle; rst_n masks it while reset is held.
  assign bus.pix_tick    = rst_n & tick;
  assign bus.hcount      = hcount_r;
  assign bus.vcount      = vcount_r;
  assign bus.hsync       = hsync_r;
  assign bus.vsync       = vsync_r;
  assign bus.active      = active_r;
  assign bus.line_start  = line_start_r;
  assign bus.frame_start = frame_start_r;

endmodule
